riscv_sim_ctrl: RTL and testbench

Synthesizable run controller for the RISC-V core. It replaces fixed-time stimulus (hard-coded reset pulse, fixed #delay then stop) with parametrised reset sequencing, cycle and retired-instruction counters, a watchdog timeout, and end-of-test detection on a tohost store. It sits between the top-level bench and RISCV_Top: it drives the core reset and snoops the core data-memory write port.

---
 rtl/riscv_sim_pkg.sv | 18 +
 rtl/riscv_sim_ctrl_sat_counter.sv | 20 ++
 rtl/riscv_sim_ctrl.sv | 132 +++++++++++++
 tb/tb_riscv_sim_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sim_pkg.sv
// Shared types and constants for the RISC-V run controller.
package riscv_sim_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // tohost value that reports a passing test
    localparam int unsigned TOHOST_PASS = 1;

    // exit code is the tohost value with the pass/fail LSB dropped
    localparam int unsigned EXIT_SHIFT = 1;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0100;

endpackage

// File: rtl/riscv_sim_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // clear has priority; count only while below the all-ones ceiling
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/riscv_sim_ctrl.sv
// Run controller: sequences core reset, counts cycles/retirements,
// runs a watchdog and detects end of test on a tohost store.
module riscv_sim_ctrl
    import riscv_sim_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 52,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              retire_valid,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instret_count
);

    localparam int unsigned HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [63:0]   WD_LAST   = 64'(TIMEOUT_CYCLES) - 64'd1;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                core_rst_nxt, done_nxt, pass_nxt, fail_nxt, timeout_nxt;
    logic [DATA_W-1:0]   exit_code_nxt;
    logic                tohost_hit, wd_hit, in_run;

    assign in_run     = (state == RUN);
    assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
    assign wd_hit     = (TIMEOUT_CYCLES != 0) && (64'(cycle_count) == WD_LAST);

    // RUN-cycle counter
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .clr (rst),
        .en  (in_run),
        .q   (cycle_count)
    );

    // retired-instruction counter
    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .clr (rst),
        .en  (in_run && retire_valid),
        .q   (instret_count)
    );

    // next-state and next-output logic; everything holds by default
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        core_rst_nxt  = core_rst;
        done_nxt      = done;
        pass_nxt      = pass;
        fail_nxt      = fail;
        timeout_nxt   = timeout;
        exit_code_nxt = exit_code;
        case (state)
            HOLD: begin
                core_rst_nxt = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = RUN;
                    core_rst_nxt = 1'b0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (tohost_hit) begin
                    state_nxt    = DONE;
                    core_rst_nxt = 1'b1;
                    done_nxt     = 1'b1;
                    if (mem_wdata == DATA_W'(TOHOST_PASS)) begin
                        pass_nxt      = 1'b1;
                        exit_code_nxt = '0;
                    end else begin
                        fail_nxt      = 1'b1;
                        exit_code_nxt = mem_wdata >> EXIT_SHIFT;
                    end
                end else if (wd_hit) begin
                    state_nxt     = DONE;
                    core_rst_nxt  = 1'b1;
                    done_nxt      = 1'b1;
                    timeout_nxt   = 1'b1;
                    fail_nxt      = 1'b1;
                    exit_code_nxt = '0;
                end
            end
            DONE: begin
                core_rst_nxt = 1'b1;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    // state and registered outputs; rst clears everything from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            core_rst  <= core_rst_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            fail      <= fail_nxt;
            timeout   <= timeout_nxt;
            exit_code <= exit_code_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// Bench for riscv_sim_ctrl: three configurations driven by shared directed
// stimulus, checked every cycle against a behavioural model plus literals.
module tb_riscv_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        retire_valid;

    // DUT outputs per instance: 0 default, 1 watchdog off, 2 CNT_W=4
    logic        core_rst_o [3];
    logic        done_o     [3];
    logic        pass_o     [3];
    logic        fail_o     [3];
    logic        timeout_o  [3];
    logic [31:0] exit_o     [3];
    logic [31:0] cc0, cc1, ic0, ic1;
    logic [3:0]  cc2, ic2;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    always #5 clk = ~clk;

    riscv_sim_ctrl u_d0 (
        .clk(clk), .rst(rst), .core_rst(core_rst_o[0]), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .timeout(timeout_o[0]),
        .exit_code(exit_o[0]), .cycle_count(cc0), .instret_count(ic0)
    );

    riscv_sim_ctrl #(.TIMEOUT_CYCLES(0)) u_d1 (
        .clk(clk), .rst(rst), .core_rst(core_rst_o[1]), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .timeout(timeout_o[1]),
        .exit_code(exit_o[1]), .cycle_count(cc1), .instret_count(ic1)
    );

    riscv_sim_ctrl #(.TIMEOUT_CYCLES(0), .CNT_W(4)) u_d2 (
        .clk(clk), .rst(rst), .core_rst(core_rst_o[2]), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .done(done_o[2]), .pass(pass_o[2]), .fail(fail_o[2]), .timeout(timeout_o[2]),
        .exit_code(exit_o[2]), .cycle_count(cc2), .instret_count(ic2)
    );

    function automatic longint cc_of(input int i);
        case (i)
            0: return longint'(cc0);
            1: return longint'(cc1);
            default: return longint'(cc2);
        endcase
    endfunction

    function automatic longint ic_of(input int i);
        case (i)
            0: return longint'(ic0);
            1: return longint'(ic1);
            default: return longint'(ic2);
        endcase
    endfunction

    // behavioural model: phase 0=reset hold, 1=running, 2=finished
    localparam int RSTC = 4;
    longint to_p  [3] = '{52, 0, 0};
    longint max_p [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    int     phase [3];
    int     held  [3];
    longint m_cc [3], m_ic [3], m_exit [3];
    bit     m_core [3], m_done [3], m_pass [3], m_fail [3], m_to [3];

    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                phase[i] = 0; held[i] = 0;
                m_cc[i] = 0; m_ic[i] = 0; m_exit[i] = 0;
                m_core[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_to[i] = 0;
            end else if (phase[i] == 0) begin
                // core_rst covers RSTC cycles once rst is low
                held[i] = held[i] + 1;
                if (held[i] == RSTC) begin
                    phase[i] = 1;
                    m_core[i] = 0;
                end
            end else if (phase[i] == 1) begin
                longint elapsed;
                elapsed = m_cc[i];
                if (m_cc[i] < max_p[i]) m_cc[i] = m_cc[i] + 1;
                if (retire_valid && m_ic[i] < max_p[i]) m_ic[i] = m_ic[i] + 1;
                if (mem_we && mem_addr == 32'h100 && mem_wdata != 0) begin
                    phase[i] = 2; m_done[i] = 1; m_core[i] = 1;
                    if (mem_wdata == 1) m_pass[i] = 1;
                    else begin
                        m_fail[i] = 1;
                        m_exit[i] = longint'(mem_wdata) / 2;
                    end
                end else if (to_p[i] != 0 && elapsed + 1 == to_p[i]) begin
                    phase[i] = 2; m_done[i] = 1; m_core[i] = 1;
                    m_to[i] = 1; m_fail[i] = 1; m_exit[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk("core_rst", i, longint'(core_rst_o[i]), longint'(m_core[i]));
                chk("done", i, longint'(done_o[i]), longint'(m_done[i]));
                chk("pass", i, longint'(pass_o[i]), longint'(m_pass[i]));
                chk("fail", i, longint'(fail_o[i]), longint'(m_fail[i]));
                chk("timeout", i, longint'(timeout_o[i]), longint'(m_to[i]));
                chk("exit_code", i, longint'(exit_o[i]), m_exit[i]);
                chk("cycle_count", i, cc_of(i), m_cc[i]);
                chk("instret_count", i, ic_of(i), m_ic[i]);
            end
        end
    end

    // drive one cycle of inputs, return at the following negedge
    task automatic step(input bit r, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input bit ret);
        rst = r; mem_we = we; mem_addr = a; mem_wdata = d; retire_valid = ret;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic restart();
        step(1, 0, 32'h0, 32'h0, 0);
        idle(RSTC);
    endtask

    initial begin
        // 1: reset sequencing
        for (int k = 0; k < 3; k++) step(1, 0, 32'h0, 32'h0, 0);
        chk("lit_rst_core", 0, longint'(core_rst_o[0]), 1);
        chk("lit_rst_done", 0, longint'(done_o[0]), 0);
        idle(3);
        chk("lit_hold_core", 0, longint'(core_rst_o[0]), 1);
        idle(1);
        chk("lit_run_core", 0, longint'(core_rst_o[0]), 0);
        chk("lit_run_cc", 0, longint'(cc0), 0);

        // 2: pass after 10 RUN cycles, 7 retirements
        for (int k = 0; k < 9; k++) step(0, 0, 32'h0, 32'h0, k < 7);
        step(0, 1, 32'h100, 32'h1, 0);
        chk("lit_pass_done", 0, longint'(done_o[0]), 1);
        chk("lit_pass_pass", 0, longint'(pass_o[0]), 1);
        chk("lit_pass_fail", 0, longint'(fail_o[0]), 0);
        chk("lit_pass_cc", 0, longint'(cc0), 10);
        chk("lit_pass_ic", 0, longint'(ic0), 7);
        chk("lit_pass_core", 0, longint'(core_rst_o[0]), 1);
        for (int k = 0; k < 3; k++) step(0, 1, 32'h100, 32'h3, 1);
        chk("lit_frozen_cc", 0, longint'(cc0), 10);
        chk("lit_frozen_fail", 0, longint'(fail_o[0]), 0);

        // 3: ignored stores then failing code; reset from the finished state first
        step(1, 0, 32'h0, 32'h0, 0);
        chk("lit_clr_done", 0, longint'(done_o[0]), 0);
        chk("lit_clr_pass", 0, longint'(pass_o[0]), 0);
        chk("lit_clr_ic", 0, longint'(ic0), 0);
        idle(RSTC);
        step(0, 1, 32'h100, 32'h0, 0);
        step(0, 1, 32'h104, 32'h1, 0);
        chk("lit_ignored", 0, longint'(done_o[0]), 0);
        idle(2);
        step(0, 1, 32'h100, 32'hB, 1);
        chk("lit_fail_fail", 0, longint'(fail_o[0]), 1);
        chk("lit_fail_pass", 0, longint'(pass_o[0]), 0);
        chk("lit_fail_exit", 0, longint'(exit_o[0]), 5);

        // 4: watchdog on dut0, disabled on dut1, saturation on dut2
        restart();
        idle(51);
        chk("lit_wd_notyet", 0, longint'(done_o[0]), 0);
        idle(1);
        chk("lit_wd_timeout", 0, longint'(timeout_o[0]), 1);
        chk("lit_wd_fail", 0, longint'(fail_o[0]), 1);
        chk("lit_wd_exit", 0, longint'(exit_o[0]), 0);
        chk("lit_wd_cc", 0, longint'(cc0), 52);
        chk("lit_sat_cc", 2, longint'(cc2), 15);
        idle(200);
        chk("lit_nowd_done", 1, longint'(done_o[1]), 0);
        chk("lit_nowd_cc", 1, longint'(cc1), 252);

        // 5: tohost hit on the expiry cycle wins over the watchdog
        restart();
        idle(51);
        step(0, 1, 32'h100, 32'h1, 0);
        chk("lit_tie_pass", 0, longint'(pass_o[0]), 1);
        chk("lit_tie_timeout", 0, longint'(timeout_o[0]), 0);
        chk("lit_tie_fail", 0, longint'(fail_o[0]), 0);

        // 6: reset mid-run restarts the hold sequence
        restart();
        for (int k = 0; k < 20; k++) step(0, 0, 32'h0, 32'h0, 1);
        chk("lit_mid_ic", 2, longint'(ic2), 15);
        step(1, 0, 32'h0, 32'h0, 1);
        chk("lit_mid_core", 0, longint'(core_rst_o[0]), 1);
        chk("lit_mid_cc", 0, longint'(cc0), 0);
        idle(3);
        chk("lit_mid_hold", 0, longint'(core_rst_o[0]), 1);
        idle(1);
        chk("lit_mid_run", 0, longint'(core_rst_o[0]), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
